fmps_link_reader: RTL and testbench
===================================

Name: fmps_link_reader

Overview:
- Single-clock receiver for the two FMPS (fast machine-protection) stream taps, CCW and CW, in the cell controller.
- Each FA cycle it collects one data word per FMPS index into per-link storage, builds presence bitmaps and tracks completion against an expected count or a timeout.
- Results are exposed to software via a CSR, an indexed readout port and a microBlaze readout port.

Parameters:
- INDEX_WIDTH, 5: FMPS index width; 2^INDEX_WIDTH slots per link.
- SYSCLK_RATE, 100000000: clock rate in Hz.
- TIMEOUT_CYCLES, SYSCLK_RATE/200000: window timeout in clocks (5 µs).

Ports:
- sysClk  in  1  clock
- sysReset_n  in  1  asynchronous active-low reset
- csrStrobe  in  1  CSR write strobe
- GPIO_OUT  in  32  CSR write data
- csr  out  32  CSR read data
- FAstrobe  in  1  FA cycle start pulse
- ccwTVALID/ccwTLAST  in  1 each  CCW tap
- ccwTDATA  in  32  CCW tap data
- cwTVALID/cwTLAST  in  1 each  CW tap
- cwTDATA  in  32  CW tap data
- fmpsBitmapAll  out  2^IW  indices received this cycle, CCW OR CW
- fmpsBitmapEnabled  out  2^IW  fmpsBitmapAll AND enable mask
- fmpsBitmapAllFASnapshot, fmpsEnableBitmapFASnapshot  out  2^IW each  values latched at FAstrobe
- fmpsEnabled  out  1  enable mask non-zero
- sysStatusStrobe  out  1  window-end pulse
- sysStatusCode  out  3  end status
- sysTimeoutStrobe  out  1  timeout pulse
- fmpsReadoutAddress  in  IW  readout index
- fmpsReadout  out  32  stored word
- uBreadoutStrobe  in  1  advance uB pointer
- uBreadout  out  32  uB word
- ccwFmpsInhibit, cwFmpsInhibit  out  1 each  link inhibits

Behaviour:
- Reset values:
  - all outputs, bitmaps, snapshots, counts and flags 0
  - enable mask all ones
  - parsers in HDR state
- Packet format: 2 beats.
  - Header: [31:16] must equal 16'hB6CF; [14:10] is the index; other bits ignored.
  - Data: stored verbatim. Sender layout: [31] invFMPS2CC, [30] invCC2CC, [29] reserved, [28:24] index, [23:8] 16'hCACA, [7:0] cycle counter.
- Parser (one per link), states HDR, DATA, DROP:
  - HDR + TVALID, good magic, !TLAST → latch index, go DATA.
  - HDR + TVALID, bad magic or TLAST → set hdrErr; go DROP if !TLAST, else stay in HDR.
  - DATA + TVALID → write word to slot, set link bitmap bit; go HDR if TLAST, else go DROP.
  - DROP: return to HDR on TVALID & TLAST.
  - Writes are discarded if the window is inactive or the link is inhibited.
  - Rewriting a set bit sets dupErr; the new data overwrites.
- CSR write:
  - GPIO_OUT[31]=0 → expected count ← [5:0] (INDEX_WIDTH+1 bits), CCW inhibit ← [18], CW inhibit ← [19].
  - GPIO_OUT[31]=1 → enableMask[GPIO_OUT[28:24]] ← GPIO_OUT[30]; no other field changes.
- CSR read: [31] active, [30] valid, [29] hdrErr, [28] dupErr, [19] CW inhibit, [18] CCW inhibit, [11:6] received count, [5:0] expected count.
- FAstrobe (next clock):
  - snapshot fmpsBitmapAll and enable mask
  - clear both link bitmaps and the error flags
  - active=1, valid=0, timer=0
  - FAstrobe during an active window first ends it with code 3.
- Received count = popcount(fmpsBitmapAll), registered.
- Count ≥ expected (nonzero) while active → active=0, valid=1, sysStatusStrobe pulse with code 0 (code 2 if hdrErr|dupErr).
- Timer reaches TIMEOUT_CYCLES → active=0, valid=0, sysTimeoutStrobe and sysStatusStrobe pulse together with code 1.
- Count reached and timeout on the same clock → completion wins.
- fmpsReadout: registered, 1-clock latency; returns the CCW slot if its CCW bit is set, else the CW slot, else 0.
  - Same index on both links in one clock → both bits set; CCW storage used for readout.

Optional Feature:
- FMPS_LINK_READER_UB_READOUT_EN defined:
  - uBreadout alternates fmpsBitmapAllFASnapshot (ptr 0) and fmpsEnableBitmapFASnapshot (ptr 1).
  - ptr toggles on uBreadoutStrobe and resets to 0 at FAstrobe.
- Undefined: uBreadout tied to 0 and the pointer is removed.

Decomposition:
- Package fmps_pkg holds:
  - header magic 16'hB6CF, data magic 16'hCACA
  - header index bit 10
  - CSR bit positions
  - status codes OK=0, TIMEOUT=1, ERR=2, OVERRUN=3
- Sub-module fmps_link_rx: parser plus 2^IW×32 RAM plus link bitmap; instantiated for CCW and CW.

Test Plan:
- Write count 16, FAstrobe, then CCW indices 0–7 and CW 8–15 → valid rises, fmpsBitmapAll=0x0000FFFF, status code 0, readout[5]=0x05CACA00|cycle.
- Count 16, only 8 packets sent → sysTimeoutStrobe after TIMEOUT_CYCLES, code 1, active=0, valid=0.
- Header 0xB6CE → nothing stored, csr[29]=1, next good packet accepted.
- CSR write bit18=1 → ccwFmpsInhibit=1, CCW packets ignored, CW packets still stored.
- Write 0x83000000 (bit31=1, index 3, value 0) → mask bit 3 cleared; fmpsBitmapEnabled[3]=0 while fmpsBitmapAll[3]=1.
- Assert sysReset_n low mid-window → all flags cleared, mask all ones, next FAstrobe starts cleanly.

Source files
------------

// File: rtl/fmps_pkg.sv
// Shared constants and types for the FMPS link reader: packet magics, CSR bit map,
// parser states and window end status codes.
package fmps_pkg;

    localparam logic [15:0] HDR_MAGIC  = 16'hB6CF;
    localparam logic [15:0] DATA_MAGIC = 16'hCACA;
    localparam int HDR_INDEX_BIT = 10;

    localparam int CSR_ACTIVE_BIT     = 31;
    localparam int CSR_VALID_BIT      = 30;
    localparam int CSR_HDR_ERR_BIT    = 29;
    localparam int CSR_DUP_ERR_BIT    = 28;
    localparam int CSR_CW_INH_BIT     = 19;
    localparam int CSR_CCW_INH_BIT    = 18;
    localparam int CSR_RX_COUNT_LSB   = 6;
    localparam int CSR_MASK_MODE_BIT  = 31;
    localparam int CSR_MASK_VALUE_BIT = 30;
    localparam int CSR_MASK_INDEX_LSB = 24;

    typedef enum logic [2:0] {
        STATUS_OK      = 3'd0,
        STATUS_TIMEOUT = 3'd1,
        STATUS_ERR     = 3'd2,
        STATUS_OVERRUN = 3'd3
    } fmpsStatus_t;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_DATA = 2'd1,
        ST_DROP = 2'd2
    } parserState_t;

endpackage

// File: rtl/fmps_link_rx.sv
// One FMPS stream tap: two-beat packet parser, per-index word storage and the
// bitmap of indices received in the current FA cycle.
module fmps_link_rx
    import fmps_pkg::*;
#(
    parameter int INDEX_WIDTH = 5
) (
    input  logic                          sysClk,
    input  logic                          sysReset_n,
    input  logic                          clear,
    input  logic                          acceptEn,
    input  logic                          tValid,
    input  logic                          tLast,
    input  logic [31:0]                   tData,
    input  logic [INDEX_WIDTH-1:0]        readAddress,
    output logic [31:0]                   readData,
    output logic [(1<<INDEX_WIDTH)-1:0]   bitmap,
    output logic                          hdrErr,
    output logic                          dupErr
);
    localparam int SLOTS = 1 << INDEX_WIDTH;

    parserState_t           state;
    logic [INDEX_WIDTH-1:0] slotIndex;
    logic [31:0]            slotMem [SLOTS];
    logic                   goodMagic;
    logic                   hdrBeat;
    logic                   storeBeat;

    assign goodMagic = (tData[31:16] == HDR_MAGIC);
    assign hdrBeat   = (state == ST_HDR) && tValid;
    assign storeBeat = (state == ST_DATA) && tValid && acceptEn;

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            state  <= ST_HDR;
            bitmap <= '0;
            hdrErr <= 1'b0;
            dupErr <= 1'b0;
        end else begin
            case (state)
                ST_HDR: begin
                    if (tValid && !tLast)
                        state <= goodMagic ? ST_DATA : ST_DROP;
                end
                ST_DATA: begin
                    if (tValid)
                        state <= tLast ? ST_HDR : ST_DROP;
                end
                ST_DROP: begin
                    if (tValid && tLast)
                        state <= ST_HDR;
                end
                default: state <= ST_HDR;
            endcase

            // The FA-cycle clear beats any flag or bitmap update on the same clock.
            if (clear) begin
                bitmap <= '0;
                hdrErr <= 1'b0;
                dupErr <= 1'b0;
            end else begin
                if (hdrBeat && (!goodMagic || tLast))
                    hdrErr <= 1'b1;
                if (storeBeat) begin
                    bitmap[slotIndex] <= 1'b1;
                    if (bitmap[slotIndex])
                        dupErr <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sysClk) begin
        if (hdrBeat)
            slotIndex <= tData[HDR_INDEX_BIT +: INDEX_WIDTH];
        if (storeBeat)
            slotMem[slotIndex] <= tData;
    end

    assign readData = slotMem[readAddress];

endmodule

// File: rtl/fmps_link_reader.sv
// FMPS CCW/CW stream receiver with per-FA-cycle completion/timeout tracking and CSR.
// Build option: define FMPS_LINK_READER_UB_READOUT_EN to enable the uB snapshot readout.
module fmps_link_reader
    import fmps_pkg::*;
#(
    parameter int INDEX_WIDTH    = 5,
    parameter int SYSCLK_RATE    = 100000000,
    parameter int TIMEOUT_CYCLES = SYSCLK_RATE / 200000
) (
    input  logic                          sysClk,
    input  logic                          sysReset_n,
    input  logic                          csrStrobe,
    input  logic [31:0]                   GPIO_OUT,
    output logic [31:0]                   csr,
    input  logic                          FAstrobe,
    input  logic                          ccwTVALID,
    input  logic                          ccwTLAST,
    input  logic [31:0]                   ccwTDATA,
    input  logic                          cwTVALID,
    input  logic                          cwTLAST,
    input  logic [31:0]                   cwTDATA,
    output logic [(1<<INDEX_WIDTH)-1:0]   fmpsBitmapAll,
    output logic [(1<<INDEX_WIDTH)-1:0]   fmpsBitmapEnabled,
    output logic [(1<<INDEX_WIDTH)-1:0]   fmpsBitmapAllFASnapshot,
    output logic [(1<<INDEX_WIDTH)-1:0]   fmpsEnableBitmapFASnapshot,
    output logic                          fmpsEnabled,
    output logic                          sysStatusStrobe,
    output logic [2:0]                    sysStatusCode,
    output logic                          sysTimeoutStrobe,
    input  logic [INDEX_WIDTH-1:0]        fmpsReadoutAddress,
    output logic [31:0]                   fmpsReadout,
    input  logic                          uBreadoutStrobe,
    output logic [31:0]                   uBreadout,
    output logic                          ccwFmpsInhibit,
    output logic                          cwFmpsInhibit
);
    localparam int SLOTS   = 1 << INDEX_WIDTH;
    localparam int COUNT_W = INDEX_WIDTH + 1;
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    function automatic logic [COUNT_W-1:0] popCount(input logic [SLOTS-1:0] bits);
        logic [COUNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < SLOTS; i++)
            n = n + COUNT_W'(bits[i]);
        return n;
    endfunction

    logic [SLOTS-1:0]   enableMask;
    logic [SLOTS-1:0]   ccwBitmap, cwBitmap;
    logic [31:0]        ccwWord, cwWord;
    logic               ccwHdrErr, cwHdrErr, ccwDupErr, cwDupErr;
    logic [COUNT_W-1:0] expectedCount, receivedCount;
    logic [TIMER_W-1:0] timer;
    logic               active, valid;
    logic               hdrErr, dupErr;
    logic               unusedCsrBits;

    assign unusedCsrBits = ^GPIO_OUT;

    fmps_link_rx #(.INDEX_WIDTH(INDEX_WIDTH)) ccwRx (
        .sysClk(sysClk), .sysReset_n(sysReset_n), .clear(FAstrobe),
        .acceptEn(active && !ccwFmpsInhibit),
        .tValid(ccwTVALID), .tLast(ccwTLAST), .tData(ccwTDATA),
        .readAddress(fmpsReadoutAddress), .readData(ccwWord),
        .bitmap(ccwBitmap), .hdrErr(ccwHdrErr), .dupErr(ccwDupErr)
    );

    fmps_link_rx #(.INDEX_WIDTH(INDEX_WIDTH)) cwRx (
        .sysClk(sysClk), .sysReset_n(sysReset_n), .clear(FAstrobe),
        .acceptEn(active && !cwFmpsInhibit),
        .tValid(cwTVALID), .tLast(cwTLAST), .tData(cwTDATA),
        .readAddress(fmpsReadoutAddress), .readData(cwWord),
        .bitmap(cwBitmap), .hdrErr(cwHdrErr), .dupErr(cwDupErr)
    );

    assign fmpsBitmapAll     = ccwBitmap | cwBitmap;
    assign fmpsBitmapEnabled = fmpsBitmapAll & enableMask;
    assign fmpsEnabled       = |enableMask;
    assign hdrErr            = ccwHdrErr | cwHdrErr;
    assign dupErr            = ccwDupErr | cwDupErr;

    always_comb begin
        csr = '0;
        csr[CSR_ACTIVE_BIT]  = active;
        csr[CSR_VALID_BIT]   = valid;
        csr[CSR_HDR_ERR_BIT] = hdrErr;
        csr[CSR_DUP_ERR_BIT] = dupErr;
        csr[CSR_CW_INH_BIT]  = cwFmpsInhibit;
        csr[CSR_CCW_INH_BIT] = ccwFmpsInhibit;
        csr[CSR_RX_COUNT_LSB +: COUNT_W] = receivedCount;
        csr[0 +: COUNT_W]    = expectedCount;
    end

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            enableMask     <= '1;
            expectedCount  <= '0;
            ccwFmpsInhibit <= 1'b0;
            cwFmpsInhibit  <= 1'b0;
        end else if (csrStrobe) begin
            if (GPIO_OUT[CSR_MASK_MODE_BIT]) begin
                enableMask[GPIO_OUT[CSR_MASK_INDEX_LSB +: INDEX_WIDTH]] <= GPIO_OUT[CSR_MASK_VALUE_BIT];
            end else begin
                expectedCount  <= GPIO_OUT[COUNT_W-1:0];
                ccwFmpsInhibit <= GPIO_OUT[CSR_CCW_INH_BIT];
                cwFmpsInhibit  <= GPIO_OUT[CSR_CW_INH_BIT];
            end
        end
    end

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            active                     <= 1'b0;
            valid                      <= 1'b0;
            timer                      <= '0;
            receivedCount              <= '0;
            fmpsBitmapAllFASnapshot    <= '0;
            fmpsEnableBitmapFASnapshot <= '0;
            sysStatusStrobe            <= 1'b0;
            sysTimeoutStrobe           <= 1'b0;
            sysStatusCode              <= STATUS_OK;
        end else begin
            sysStatusStrobe  <= 1'b0;
            sysTimeoutStrobe <= 1'b0;
            // Zeroed at FAstrobe so the stale count of the previous cycle cannot complete the new window.
            receivedCount <= FAstrobe ? '0 : popCount(fmpsBitmapAll);

            if (FAstrobe) begin
                fmpsBitmapAllFASnapshot    <= fmpsBitmapAll;
                fmpsEnableBitmapFASnapshot <= enableMask;
                if (active) begin
                    sysStatusStrobe <= 1'b1;
                    sysStatusCode   <= STATUS_OVERRUN;
                end
                active <= 1'b1;
                valid  <= 1'b0;
                timer  <= '0;
            end else if (active) begin
                if ((expectedCount != '0) && (receivedCount >= expectedCount)) begin
                    active          <= 1'b0;
                    valid           <= 1'b1;
                    sysStatusStrobe <= 1'b1;
                    sysStatusCode   <= (hdrErr || dupErr) ? STATUS_ERR : STATUS_OK;
                end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    active           <= 1'b0;
                    valid            <= 1'b0;
                    sysStatusStrobe  <= 1'b1;
                    sysTimeoutStrobe <= 1'b1;
                    sysStatusCode    <= STATUS_TIMEOUT;
                end else begin
                    timer <= timer + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n)
            fmpsReadout <= '0;
        else if (ccwBitmap[fmpsReadoutAddress])
            fmpsReadout <= ccwWord;
        else if (cwBitmap[fmpsReadoutAddress])
            fmpsReadout <= cwWord;
        else
            fmpsReadout <= '0;
    end

`ifdef FMPS_LINK_READER_UB_READOUT_EN
    logic uBPtr;

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n)
            uBPtr <= 1'b0;
        else if (FAstrobe)
            uBPtr <= 1'b0;
        else if (uBreadoutStrobe)
            uBPtr <= ~uBPtr;
    end

    assign uBreadout = 32'(uBPtr ? fmpsEnableBitmapFASnapshot : fmpsBitmapAllFASnapshot);
`else
    logic unusedUbStrobe;

    assign unusedUbStrobe = uBreadoutStrobe;
    assign uBreadout      = '0;
`endif

endmodule

// File: tb/tb_fmps_link_reader.sv
// Directed bench for fmps_link_reader: readout vector table plus hand-written window sequences.
module tb_fmps_link_reader;

    logic        sysClk = 1'b0;
    logic        sysReset_n = 1'b0;
    logic        csrStrobe = 1'b0;
    logic [31:0] GPIO_OUT = '0;
    logic [31:0] csr;
    logic        FAstrobe = 1'b0;
    logic        ccwTVALID = 1'b0, ccwTLAST = 1'b0;
    logic [31:0] ccwTDATA = '0;
    logic        cwTVALID = 1'b0, cwTLAST = 1'b0;
    logic [31:0] cwTDATA = '0;
    logic [31:0] fmpsBitmapAll, fmpsBitmapEnabled;
    logic [31:0] fmpsBitmapAllFASnapshot, fmpsEnableBitmapFASnapshot;
    logic        fmpsEnabled, sysStatusStrobe, sysTimeoutStrobe;
    logic [2:0]  sysStatusCode;
    logic [4:0]  fmpsReadoutAddress = '0;
    logic [31:0] fmpsReadout;
    logic        uBreadoutStrobe = 1'b0;
    logic [31:0] uBreadout;
    logic        ccwFmpsInhibit, cwFmpsInhibit;

    int nChecks = 0;
    int nPass   = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] expWord;
    } rdVec_t;
    rdVec_t rdTab[7];

    fmps_link_reader dut (
        .sysClk(sysClk), .sysReset_n(sysReset_n),
        .csrStrobe(csrStrobe), .GPIO_OUT(GPIO_OUT), .csr(csr),
        .FAstrobe(FAstrobe),
        .ccwTVALID(ccwTVALID), .ccwTLAST(ccwTLAST), .ccwTDATA(ccwTDATA),
        .cwTVALID(cwTVALID), .cwTLAST(cwTLAST), .cwTDATA(cwTDATA),
        .fmpsBitmapAll(fmpsBitmapAll), .fmpsBitmapEnabled(fmpsBitmapEnabled),
        .fmpsBitmapAllFASnapshot(fmpsBitmapAllFASnapshot),
        .fmpsEnableBitmapFASnapshot(fmpsEnableBitmapFASnapshot),
        .fmpsEnabled(fmpsEnabled),
        .sysStatusStrobe(sysStatusStrobe), .sysStatusCode(sysStatusCode),
        .sysTimeoutStrobe(sysTimeoutStrobe),
        .fmpsReadoutAddress(fmpsReadoutAddress), .fmpsReadout(fmpsReadout),
        .uBreadoutStrobe(uBreadoutStrobe), .uBreadout(uBreadout),
        .ccwFmpsInhibit(ccwFmpsInhibit), .cwFmpsInhibit(cwFmpsInhibit)
    );

    always #5 sysClk = ~sysClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act === req) nPass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    endtask

    function automatic logic [31:0] hdrWord(input logic [15:0] magic, input logic [4:0] idx);
        return {magic, 1'b0, idx, 10'h0};
    endfunction

    function automatic logic [31:0] datWord(input logic [4:0] idx, input logic [7:0] cyc);
        return {3'b000, idx, 16'hCACA, cyc};
    endfunction

    task automatic sendPkt(input bit onCcw, input bit onCw, input logic [31:0] hdr,
                           input logic [31:0] ccwDat, input logic [31:0] cwDat);
        @(negedge sysClk);
        ccwTVALID = onCcw; ccwTLAST = 1'b0; ccwTDATA = hdr;
        cwTVALID  = onCw;  cwTLAST  = 1'b0; cwTDATA  = hdr;
        @(negedge sysClk);
        ccwTLAST = onCcw; ccwTDATA = ccwDat;
        cwTLAST  = onCw;  cwTDATA  = cwDat;
        @(negedge sysClk);
        ccwTVALID = 1'b0; ccwTLAST = 1'b0;
        cwTVALID  = 1'b0; cwTLAST  = 1'b0;
    endtask

    task automatic sendGood(input bit onCw, input logic [4:0] idx, input logic [7:0] cyc);
        sendPkt(!onCw, onCw, hdrWord(16'hB6CF, idx), datWord(idx, cyc), datWord(idx, cyc));
    endtask

    task automatic csrWrite(input logic [31:0] v);
        @(negedge sysClk);
        csrStrobe = 1'b1; GPIO_OUT = v;
        @(negedge sysClk);
        csrStrobe = 1'b0;
    endtask

    task automatic faPulse();
        @(negedge sysClk);
        FAstrobe = 1'b1;
        @(negedge sysClk);
        FAstrobe = 1'b0;
    endtask

    task automatic waitStatus(input int maxCyc, output bit seen, output logic [2:0] code, output bit tmo);
        seen = 1'b0; code = '0; tmo = 1'b0;
        for (int i = 0; i < maxCyc && !seen; i++) begin
            @(negedge sysClk);
            if (sysStatusStrobe) begin
                seen = 1'b1; code = sysStatusCode; tmo = sysTimeoutStrobe;
            end
        end
    endtask

    task automatic readSlot(input logic [4:0] addr, output logic [31:0] word);
        @(negedge sysClk);
        fmpsReadoutAddress = addr;
        @(negedge sysClk);
        word = fmpsReadout;
    endtask

    initial begin
        bit          seen, tmo;
        logic [2:0]  code;
        logic [31:0] word;

        rdTab[0] = '{5'd0,  32'h00CACA11};
        rdTab[1] = '{5'd5,  32'h05CACA11};
        rdTab[2] = '{5'd7,  32'h07CACA11};
        rdTab[3] = '{5'd8,  32'h08CACA11};
        rdTab[4] = '{5'd15, 32'h0FCACA11};
        rdTab[5] = '{5'd16, 32'h00000000};
        rdTab[6] = '{5'd31, 32'h00000000};

        repeat (3) @(negedge sysClk);
        check("reset csr", csr, 32'h0);
        check("reset bitmapAll", fmpsBitmapAll, 32'h0);
        check("reset fmpsEnabled", 32'(fmpsEnabled), 32'h1);
        check("reset readout", fmpsReadout, 32'h0);
        sysReset_n = 1'b1;
        @(negedge sysClk);

        // Full window: 8 CCW + 8 CW packets against an expected count of 16.
        csrWrite(32'd16);
        check("count written", 32'(csr[5:0]), 32'd16);
        faPulse();
        check("window active", 32'(csr[31]), 32'h1);
        for (int i = 0; i < 8; i++) sendGood(1'b0, 5'(i), 8'h11);
        for (int i = 8; i < 16; i++) sendGood(1'b1, 5'(i), 8'h11);
        waitStatus(50, seen, code, tmo);
        check("complete strobe", 32'(seen), 32'h1);
        check("complete code", 32'(code), 32'd0);
        check("complete no timeout", 32'(tmo), 32'h0);
        check("complete active/valid", 32'(csr[31:30]), 32'h1);
        check("complete bitmapAll", fmpsBitmapAll, 32'h0000FFFF);
        check("complete bitmapEnabled", fmpsBitmapEnabled, 32'h0000FFFF);
        check("complete rx count", 32'(csr[11:6]), 32'd16);
        for (int i = 0; i < 7; i++) begin
            readSlot(rdTab[i].addr, word);
            check($sformatf("readout[%0d]", rdTab[i].addr), word, rdTab[i].expWord);
        end

        // Short window: only 8 packets arrive, so the timer must end it.
        faPulse();
        check("snapshot all", fmpsBitmapAllFASnapshot, 32'h0000FFFF);
        check("snapshot enable", fmpsEnableBitmapFASnapshot, 32'hFFFFFFFF);
        check("bitmap cleared", fmpsBitmapAll, 32'h0);
`ifdef FMPS_LINK_READER_UB_READOUT_EN
        check("uB ptr0", uBreadout, 32'h0000FFFF);
        @(negedge sysClk); uBreadoutStrobe = 1'b1;
        @(negedge sysClk); uBreadoutStrobe = 1'b0;
        check("uB ptr1", uBreadout, 32'hFFFFFFFF);
`else
        check("uB tied off", uBreadout, 32'h0);
`endif
        for (int i = 0; i < 8; i++) sendGood(1'b0, 5'(i), 8'h22);
        waitStatus(700, seen, code, tmo);
        check("timeout strobe", 32'(seen), 32'h1);
        check("timeout code", 32'(code), 32'd1);
        check("timeout flag", 32'(tmo), 32'h1);
        check("timeout active/valid", 32'(csr[31:30]), 32'h0);
        check("timeout bitmapAll", fmpsBitmapAll, 32'h000000FF);

        // Bad header magic is dropped and flagged; the following good packet lands.
        faPulse();
        sendPkt(1'b1, 1'b0, hdrWord(16'hB6CE, 5'd2), datWord(5'd2, 8'h33), 32'h0);
        check("bad hdr hdrErr", 32'(csr[29]), 32'h1);
        check("bad hdr nothing stored", fmpsBitmapAll, 32'h0);
        sendGood(1'b0, 5'd2, 8'h33);
        check("good after bad", fmpsBitmapAll, 32'h00000004);

        // FAstrobe inside a live window reports overrun and clears the error flags.
        faPulse();
        check("overrun strobe", 32'(sysStatusStrobe), 32'h1);
        check("overrun code", 32'(sysStatusCode), 32'd3);
        check("overrun flags cleared", 32'(csr[29:28]), 32'h0);

        // CCW inhibit: CCW packets ignored, CW still stored.
        csrWrite(32'h0004_0010);
        check("ccw inhibit out", 32'(ccwFmpsInhibit), 32'h1);
        check("ccw inhibit csr", 32'(csr[19:18]), 32'h1);
        sendGood(1'b0, 5'd3, 8'h44);
        sendGood(1'b1, 5'd4, 8'h44);
        check("inhibit bitmapAll", fmpsBitmapAll, 32'h00000010);
        csrWrite(32'h0000_0010);

        // Clearing enable bit 3 hides index 3 from the enabled bitmap only.
        csrWrite(32'h8300_0000);
        check("mask keeps count", 32'(csr[5:0]), 32'd16);
        sendGood(1'b0, 5'd3, 8'h55);
        check("mask bitmapAll", fmpsBitmapAll, 32'h00000018);
        check("mask bitmapEnabled", fmpsBitmapEnabled, 32'h00000010);
        check("mask fmpsEnabled", 32'(fmpsEnabled), 32'h1);

        // Same index on both links in one clock: CCW copy wins the readout.
        sendPkt(1'b1, 1'b1, hdrWord(16'hB6CF, 5'd6), 32'h06CACA66, 32'h86CACA77);
        check("both links bitmap", fmpsBitmapAll, 32'h00000058);
        readSlot(5'd6, word);
        check("both links readout", word, 32'h06CACA66);
        check("no dup yet", 32'(csr[28]), 32'h0);
        sendPkt(1'b1, 1'b0, hdrWord(16'hB6CF, 5'd6), 32'h06CACA99, 32'h0);
        check("dupErr set", 32'(csr[28]), 32'h1);
        readSlot(5'd6, word);
        check("dup overwrites", word, 32'h06CACA99);

        // Reset in the middle of the window restores defaults.
        @(negedge sysClk); sysReset_n = 1'b0;
        @(negedge sysClk);
        check("midreset csr", csr, 32'h0);
        check("midreset bitmap", fmpsBitmapAll, 32'h0);
        check("midreset inhibit", 32'(ccwFmpsInhibit), 32'h0);
        @(negedge sysClk); sysReset_n = 1'b1;
        csrWrite(32'd1);
        faPulse();
        sendGood(1'b0, 5'd3, 8'h66);
        waitStatus(50, seen, code, tmo);
        check("post-reset strobe", 32'(seen), 32'h1);
        check("post-reset code", 32'(code), 32'd0);
        check("post-reset mask bit3", fmpsBitmapEnabled, 32'h00000008);
        faPulse();
        check("post-reset enable snapshot", fmpsEnableBitmapFASnapshot, 32'hFFFFFFFF);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
